mdu_issue_ctrl: RTL

- E-stage initiator for the multiply/divide unit; drives its start/op inputs and consumes its Busy.
- Decides when an MDU operation is launched and suppresses the launch on an exception/interrupt request.
- Generates the D-stage stall for any MDU-class instruction while an operation is in flight or settling.
- Tracks the handshake with a small FSM and flags protocol violations (missing Busy, timeout).

---
 rtl/mdu_issue_ctrl_pkg.sv | 26 ++
 rtl/mdu_wait_timer.sv | 27 ++
 rtl/mdu_issue_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU definitions: op codes, issue-controller FSM states and op-class helper.
package mdu_issue_ctrl_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_SETTLE = 2'd3
  } mdu_state_e;

  // True for ops that occupy the MDU datapath (mult/multu/div/divu).
  function automatic logic is_md(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_wait_timer.sv
// Up-counter of non-frozen WAIT cycles; done_c flags the cycle that reaches TIMEOUT.
module mdu_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done_c
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [W-1:0] count;

  // The TIMEOUT-th counted cycle is the one where count holds TIMEOUT-1.
  assign done_c = en && (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !done_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU launch control, D-stage stall generation and handshake monitor.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             e_valid,
  input  logic [3:0]       e_op,
  input  logic             d_is_mdu,
  input  logic             mdu_busy,
  output logic             mdu_start,
  output logic [3:0]       mdu_ctr,
  output logic             stall_d,
  output logic             proto_err,
  output logic [CNT_W-1:0] issue_count,
  output logic [1:0]       state_o
);

  mdu_state_e state;
  logic       e_md_c;
  logic       timer_clear_c;
  logic       timer_en_c;
  logic       timeout_c;

  assign e_md_c    = e_valid & is_md(e_op) & ~req;
  assign mdu_start = ~reset & e_md_c & (state == S_IDLE);
  assign mdu_ctr   = (~reset & e_valid & ~req) ? e_op : MDU_NONE;
  assign stall_d   = d_is_mdu & (mdu_start | (state != S_IDLE));
  assign state_o   = state;

  // The MDU freezes its countdown under req, so the timer freezes with it.
  assign timer_clear_c = (state == S_ISSUE);
  assign timer_en_c    = (state == S_WAIT) & mdu_busy & ~req;

  mdu_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear_c),
    .en     (timer_en_c),
    .done_c (timeout_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      proto_err   <= 1'b0;
      issue_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mdu_start) begin
            state       <= S_ISSUE;
            issue_count <= issue_count + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (!req) begin
            if (mdu_busy) begin
              state <= S_WAIT;
            end else begin
              proto_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          if (!mdu_busy) begin
            state <= S_SETTLE;
          end else if (timeout_c) begin
            proto_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // A launchable op reaching E mid-operation means the stall was bypassed.
      if ((state != S_IDLE) && e_md_c) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
